// File: rtl/i2c_target_if.sv
// i2c_target_if -- host-side and SCL signals of the I2C target.
//   scl        : I2C clock from the bus master (target never stretches)
//   wr_strobe  : 1-cycle pulse per accepted data byte write
//   wr_addr    : register index of that write
//   wr_data    : byte written
//   rd_addr    : host-side read index into the register file
//   rd_data    : reg[rd_addr], registered; 8'hFF when out of range
//   busy       : high from addressed ACK to STOP / repeated START
// The open-drain sda line is kept as a plain inout port on the target so the
// wired-AND resolves at the module boundary rather than inside an interface.
interface i2c_target_if;
    logic       scl;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;

    modport slave (
        input  scl, rd_addr,
        output wr_strobe, wr_addr, wr_data, rd_data, busy
    );

    modport master (
        output scl, rd_addr,
        input  wr_strobe, wr_addr, wr_data, rd_data, busy
    );
endinterface

// File: rtl/i2c_target.sv
// i2c_target -- I2C target responder with an internal 8-bit register file.
// Decodes START/STOP, matches a 7-bit device address, accepts a register
// pointer followed by write data, or returns data from the pointer on reads.
//   clk_50 : system clock, all logic on posedge
//   reset  : synchronous, active-high
//   bus    : i2c_target_if.slave (scl, host write strobe/read port, busy)
//   sda    : open-drain data line, driven 1'b0 or released (1'bz)
module i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         NREGS       = 16,
    parameter int         HOLD_CYCLES = 8
) (
    input  logic         clk_50,
    input  logic         reset,
    i2c_target_if.slave  bus,
    inout  wire          sda
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
    } state_t;

    logic          scl_s1_q, scl_s2_q, scl_s3_q;
    logic          sda_s1_q, sda_s2_q, sda_s3_q;
    state_t        state_q;
    logic [3:0]    bitcnt_q;
    logic [7:0]    shift_q;
    logic [7:0]    ptr_q;
    logic          rw_q;
    logic          ack_q;
    logic          sda_low_q;
    logic          hold_run_q;
    logic [HW-1:0] hold_cnt_q;
    logic          busy_q;
    logic          wr_strobe_q;
    logic [7:0]    wr_addr_q;
    logic [7:0]    wr_data_q;
    logic [7:0]    rd_data_q;
    logic [7:0]    regs_q [NREGS];

    logic       scl_rise, scl_fall, start_cond, stop_cond;
    logic [7:0] byte_d, ptr_inc_d, cur_rd_d, nxt_rd_d;

    function automatic logic in_range(input logic [7:0] a);
        return {24'd0, a} < NREGS;
    endfunction

    always_comb begin
        scl_rise   = scl_s2_q & ~scl_s3_q;
        scl_fall   = ~scl_s2_q & scl_s3_q;
        start_cond = scl_s2_q & scl_s3_q & sda_s3_q & ~sda_s2_q;
        stop_cond  = scl_s2_q & scl_s3_q & ~sda_s3_q & sda_s2_q;
        byte_d     = {shift_q[6:0], sda_s2_q};
        ptr_inc_d  = ptr_q + 8'd1;
        cur_rd_d   = in_range(ptr_q)     ? regs_q[ptr_q[AW-1:0]]     : 8'hFF;
        nxt_rd_d   = in_range(ptr_inc_d) ? regs_q[ptr_inc_d[AW-1:0]] : 8'hFF;
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            scl_s1_q    <= 1'b1;
            scl_s2_q    <= 1'b1;
            scl_s3_q    <= 1'b1;
            sda_s1_q    <= 1'b1;
            sda_s2_q    <= 1'b1;
            sda_s3_q    <= 1'b1;
            state_q     <= S_IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            ack_q       <= 1'b0;
            sda_low_q   <= 1'b0;
            hold_run_q  <= 1'b0;
            hold_cnt_q  <= '0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            scl_s1_q    <= bus.scl;
            scl_s2_q    <= scl_s1_q;
            scl_s3_q    <= scl_s2_q;
            sda_s1_q    <= sda;
            sda_s2_q    <= sda_s1_q;
            sda_s3_q    <= sda_s2_q;
            wr_strobe_q <= 1'b0;

            // SDA only changes HOLD_CYCLES after an SCL fall; the value
            // applied depends on the state in force when the timer expires.
            if (hold_run_q) begin
                if (hold_cnt_q == '0) begin
                    hold_run_q <= 1'b0;
                    case (state_q)
                        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: sda_low_q <= ack_q;
                        S_RDATA:                            sda_low_q <= ~shift_q[7];
                        default:                            sda_low_q <= 1'b0;
                    endcase
                end else begin
                    hold_cnt_q <= hold_cnt_q - 1'b1;
                end
            end

            if (start_cond) begin
                state_q    <= S_ADDR;
                bitcnt_q   <= '0;
                sda_low_q  <= 1'b0;
                hold_run_q <= 1'b0;
                busy_q     <= 1'b0;
            end else if (stop_cond) begin
                state_q    <= S_IDLE;
                sda_low_q  <= 1'b0;
                hold_run_q <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                if (scl_fall && state_q != S_IDLE && state_q != S_IGNORE) begin
                    hold_run_q <= 1'b1;
                    hold_cnt_q <= HW'(HOLD_CYCLES - 1);
                end
                case (state_q)
                    S_ADDR, S_PTR, S_WDATA: begin
                        if (scl_rise) begin
                            shift_q  <= byte_d;
                            bitcnt_q <= bitcnt_q + 4'd1;
                            if (bitcnt_q == 4'd7) begin
                                bitcnt_q <= '0;
                                if (state_q == S_ADDR) begin
                                    if (byte_d[7:1] == DEV_ADDR) begin
                                        state_q <= S_ADDR_ACK;
                                        ack_q   <= 1'b1;
                                        rw_q    <= byte_d[0];
                                        busy_q  <= 1'b1;
                                    end else begin
                                        state_q <= S_IGNORE;
                                    end
                                end else if (state_q == S_PTR) begin
                                    ptr_q   <= byte_d;
                                    ack_q   <= 1'b1;
                                    state_q <= S_PTR_ACK;
                                end else begin
                                    state_q <= S_WDATA_ACK;
                                    if (in_range(ptr_q)) begin
                                        regs_q[ptr_q[AW-1:0]] <= byte_d;
                                        wr_strobe_q <= 1'b1;
                                        wr_addr_q   <= ptr_q;
                                        wr_data_q   <= byte_d;
                                        ptr_q       <= ptr_inc_d;
                                        ack_q       <= 1'b1;
                                    end else begin
                                        ack_q <= 1'b0;
                                    end
                                end
                            end
                        end
                    end
                    // ACK states are entered on the 8th rise; bitcnt_q marks the
                    // 9th rise so the exit happens on the fall that ends the ACK.
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                        if (scl_rise) begin
                            bitcnt_q <= 4'd1;
                        end else if (scl_fall && bitcnt_q == 4'd1) begin
                            bitcnt_q <= '0;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                shift_q <= cur_rd_d;
                                state_q <= S_RDATA;
                            end else if (state_q == S_ADDR_ACK) begin
                                state_q <= S_PTR;
                            end else begin
                                state_q <= S_WDATA;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (scl_rise) begin
                            bitcnt_q <= bitcnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (bitcnt_q == 4'd8) begin
                                bitcnt_q <= '0;
                                state_q  <= S_RDATA_ACK;
                            end else if (bitcnt_q != 4'd0) begin
                                shift_q <= {shift_q[6:0], 1'b0};
                            end
                        end
                    end
                    S_RDATA_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s2_q) begin
                                ptr_q    <= ptr_inc_d;
                                shift_q  <= nxt_rd_d;
                                bitcnt_q <= '0;
                                state_q  <= S_RDATA;
                            end else begin
                                state_q <= S_IGNORE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Host read port reads the pre-write contents on a same-cycle collision.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= in_range(bus.rd_addr) ? regs_q[bus.rd_addr[AW-1:0]] : 8'hFF;
        end
    end

    assign sda           = sda_low_q ? 1'b0 : 1'bz;
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target -- drives i2c_target as a bus master with directed and random
// write/read transactions, checking ACKs, read data, write strobes, busy and
// the host read port against a register-file/pointer model.
module tb_i2c_target;
    localparam logic [6:0] DEV   = 7'h1A;
    localparam int         NREGS = 16;
    localparam int         Q     = 12;

    logic clk_50 = 1'b0;
    logic reset;
    logic m_low;
    wire  sda;

    i2c_target_if bus ();

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_target #(.DEV_ADDR(DEV), .NREGS(NREGS), .HOLD_CYCLES(8)) dut (
        .clk_50 (clk_50),
        .reset  (reset),
        .bus    (bus.slave),
        .sda    (sda)
    );

    always #10 clk_50 = ~clk_50;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  mregs [NREGS];
    logic [7:0]  mptr;
    logic [7:0]  wdata [8];
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];

    always @(negedge clk_50) if (bus.wr_strobe === 1'b1) got_q.push_back({bus.wr_addr, bus.wr_data});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mread(input logic [7:0] a);
        return (int'(a) < NREGS) ? mregs[a[3:0]] : 8'hFF;
    endfunction

    task automatic wait_q();
        repeat (Q) @(negedge clk_50);
    endtask

    task automatic bit_cycle(input logic b, output logic seen);
        m_low = !b;
        wait_q();
        bus.scl = 1'b1;
        wait_q();
        seen = sda;
        wait_q();
        bus.scl = 1'b0;
        wait_q();
    endtask

    task automatic send_start();
        m_low = 1'b0;
        wait_q();
        bus.scl = 1'b1;
        wait_q();
        m_low = 1'b1;
        wait_q();
        bus.scl = 1'b0;
        wait_q();
    endtask

    task automatic send_stop();
        m_low = 1'b1;
        wait_q();
        bus.scl = 1'b1;
        wait_q();
        m_low = 1'b0;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
        bit_cycle(1'b1, s);
        acked = (s === 1'b0);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] b);
        logic s;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            bit_cycle(1'b1, s);
            b = {b[6:0], s};
        end
        bit_cycle(!master_ack, s);
    endtask

    task automatic host_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bus.rd_addr = a;
        repeat (2) @(negedge clk_50);
        chk(tag, bus.rd_data, exp);
    endtask

    task automatic txn_write(input logic [7:0] p, input int n, input string tag);
        logic a;
        logic ea;
        got_q.delete();
        exp_q.delete();
        send_start();
        write_byte({DEV, 1'b0}, a);
        chk({tag, "_addr_ack"}, a, 1'b1);
        chk({tag, "_busy1"}, bus.busy, 1'b1);
        write_byte(p, a);
        chk({tag, "_ptr_ack"}, a, 1'b1);
        mptr = p;
        for (int i = 0; i < n; i++) begin
            ea = int'(mptr) < NREGS;
            if (ea) begin
                mregs[mptr[3:0]] = wdata[i];
                exp_q.push_back({mptr, wdata[i]});
                mptr = mptr + 8'd1;
            end
            write_byte(wdata[i], a);
            chk($sformatf("%s_data_ack%0d", tag, i), a, ea);
        end
        send_stop();
        chk({tag, "_busy0"}, bus.busy, 1'b0);
        chk({tag, "_nstrobe"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_strobe%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic txn_read(input logic [7:0] p, input int n, input string tag);
        logic       a;
        logic [7:0] b;
        got_q.delete();
        send_start();
        write_byte({DEV, 1'b0}, a);
        chk({tag, "_waddr_ack"}, a, 1'b1);
        write_byte(p, a);
        chk({tag, "_ptr_ack"}, a, 1'b1);
        mptr = p;
        send_start();
        write_byte({DEV, 1'b1}, a);
        chk({tag, "_raddr_ack"}, a, 1'b1);
        chk({tag, "_busy1"}, bus.busy, 1'b1);
        for (int i = 0; i < n; i++) begin
            read_byte(i < n - 1, b);
            chk($sformatf("%s_rd%0d", tag, i), b, mread(mptr));
            if (i < n - 1) mptr = mptr + 8'd1;
        end
        send_stop();
        chk({tag, "_busy0"}, bus.busy, 1'b0);
        chk({tag, "_nstrobe"}, got_q.size(), 0);
    endtask

    initial begin
        logic       a;
        logic       s;
        logic [7:0] eb;
        int         op;
        int         n;
        logic [7:0] p;

        reset       = 1'b1;
        m_low       = 1'b0;
        bus.scl     = 1'b1;
        bus.rd_addr = 8'h00;
        for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
        mptr = 8'h00;
        repeat (2) @(negedge clk_50);
        chk("rst_sda", sda, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_strobe", bus.wr_strobe, 1'b0);
        chk("rst_rddata", bus.rd_data, 8'h00);
        reset = 1'b0;
        host_chk("rst_reg0", 8'h00, 8'h00);

        // single write, then host readback
        wdata[0] = 8'hA7;
        txn_write(8'h05, 1, "w5");
        host_chk("host_reg5", 8'h05, 8'hA7);

        // address mismatch: no ACK, ignored traffic, no busy
        got_q.delete();
        send_start();
        write_byte({7'h1B, 1'b0}, a);
        chk("nomatch_ack", a, 1'b0);
        chk("nomatch_busy", bus.busy, 1'b0);
        write_byte(8'h00, a);
        chk("nomatch_ign_ack", a, 1'b0);
        send_stop();
        chk("nomatch_nstrobe", got_q.size(), 0);

        // write across the end of the register file
        wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33;
        txn_write(8'h0E, 3, "wend");
        host_chk("host_reg14", 8'h0E, 8'h11);
        host_chk("host_reg15", 8'h0F, 8'h22);

        // pointer write, repeated START, read two bytes
        txn_read(8'h05, 2, "rs");

        // STOP in the middle of a data byte
        got_q.delete();
        send_start();
        write_byte({DEV, 1'b0}, a);
        chk("mid_addr_ack", a, 1'b1);
        write_byte(8'h03, a);
        chk("mid_ptr_ack", a, 1'b1);
        bit_cycle(1'b1, s); bit_cycle(1'b0, s); bit_cycle(1'b1, s); bit_cycle(1'b0, s);
        send_stop();
        chk("mid_busy", bus.busy, 1'b0);
        chk("mid_nstrobe", got_q.size(), 0);
        write_byte({DEV, 1'b0}, a);
        chk("idle_no_ack", a, 1'b0);
        send_stop();

        // reset while the target is driving a read bit
        send_start();
        write_byte({DEV, 1'b0}, a);
        write_byte(8'h00, a);
        send_start();
        write_byte({DEV, 1'b1}, a);
        chk("rr_addr_ack", a, 1'b1);
        eb = mread(8'h00);
        m_low = 1'b0;
        wait_q();
        bus.scl = 1'b1;
        wait_q();
        chk("rr_drive", sda, eb[7]);
        reset = 1'b1;
        repeat (2) @(negedge clk_50);
        reset = 1'b0;
        repeat (2) @(negedge clk_50);
        chk("rr_sda_rel", sda, 1'b1);
        chk("rr_busy", bus.busy, 1'b0);
        for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
        mptr = 8'h00;
        bus.scl = 1'b0;
        wait_q();
        write_byte({DEV, 1'b0}, a);
        chk("rr_ignored", a, 1'b0);
        send_stop();
        host_chk("rr_reg5_clr", 8'h05, 8'h00);

        // pointer boundaries: last register, out of range, 8-bit wrap on read
        wdata[0] = 8'h5C;
        txn_write(8'h00, 1, "w0");
        wdata[0] = 8'h9D; wdata[1] = 8'h44;
        txn_write(8'h0F, 2, "wlast");
        txn_write(8'hFF, 2, "wff");
        txn_read(8'hFF, 2, "rwrap");
        txn_read(8'h0F, 2, "rlast");

        for (int k = 0; k < 12; k++) begin
            op = $urandom_range(0, 1);
            p  = 8'($urandom_range(0, NREGS + 2));
            n  = $urandom_range(1, 3);
            if (op == 0) begin
                for (int i = 0; i < n; i++) wdata[i] = 8'($urandom);
                txn_write(p, n, $sformatf("rndw%0d", k));
            end else begin
                txn_read(p, n, $sformatf("rndr%0d", k));
            end
        end

        for (int i = 0; i < NREGS + 2; i++) host_chk($sformatf("host%0d", i), 8'(i), mread(8'(i)));
        host_chk("host255", 8'hFF, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
